alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1: ALU result latency in clock cycles, legal range 1..7.
REQ-002 SHALL have ports as listed:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when REQ_VALID && REQ_READY.
- REQ_A  in  16  operand A.
- REQ_B  in  16  operand B.
- REQ_FUN  in  4  ALU opcode.
- A  out  16  operand to ALU.
- B  out  16  operand to ALU.
- ALU_FUN  out  4  opcode to ALU.
- ALU_OUT  in  16  ALU result.
- ALU_FLAGS  in  5  {Shift, CMP, Logic, Arith, Carry} flags from the ALU, bit 0 = Carry.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumed when RSP_VALID && RSP_READY.
- RSP_DATA  out  16  captured result.
- RSP_FLAGS  out  5  captured flags.
- RSP_ERR  out  1  command rejected (divide by zero).
- OP_CNT  out  8  count of completed responses.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, RESP; REQ_READY=1 only in IDLE; RSP_VALID=1 only in RESP.
REQ-004 On acceptance edge E0, SHALL register REQ_A/REQ_B/REQ_FUN onto A/B/ALU_FUN, load latency counter with ALU_LAT, enter BUSY.
REQ-005 A, B, ALU_FUN SHALL remain stable throughout BUSY.
REQ-006 In IDLE and RESP, ALU_FUN SHALL be 4'b1111 (NOP); A and B SHALL hold their last values.
REQ-007 BUSY SHALL last ALU_LAT+1 cycles; at edge E0+ALU_LAT+1 SHALL capture ALU_OUT into RSP_DATA and ALU_FLAGS into RSP_FLAGS, clear RSP_ERR, and enter RESP.
REQ-008 RSP_VALID SHALL therefore rise ALU_LAT+1 cycles after acceptance (2 cycles at default).
REQ-009 RSP_DATA, RSP_FLAGS and RSP_ERR SHALL hold stable while RSP_VALID=1 && RSP_READY=0.
REQ-010 On the RSP handshake edge SHALL return to IDLE and increment OP_CNT; OP_CNT SHALL wrap from 255 to 0.
REQ-011 REQ_VALID SHALL be ignored outside IDLE; a new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-012 Opcodes 4'b1111 SHALL still traverse BUSY and return whatever the ALU produces.

Reset
REQ-013 RST low SHALL asynchronously force: state IDLE, REQ_READY=1 after release, RSP_VALID=0, RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=0, A=0, B=0, ALU_FUN=4'b1111, OP_CNT=0.
REQ-014 Reset asserted mid-BUSY or mid-RESP SHALL abandon the command with no response and no OP_CNT increment.

Configuration
REQ-015 With ALU_CMD_SEQ_DIV0_CHK_EN defined: an accepted REQ_FUN=4'b0011 with REQ_B=0 SHALL go IDLE->RESP directly at E0, with RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=1; the ALU ports SHALL not change; OP_CNT SHALL still increment on the handshake.
REQ-016 Without ALU_CMD_SEQ_DIV0_CHK_EN: divide-by-zero SHALL be issued like any command, and RSP_ERR SHALL be constant 0.

Structure
REQ-017 Shared package alu_pkg SHALL hold the opcode constants (ADD=0000, SUB=0001, MUL=0010, DIV=0011, AND=0100, OR=0101, NAND=0110, NOR=0111, XOR=1000, XNOR=1001, CMPEQ=1010, CMPG=1011, CMPL=1100, SHR=1101, SHL=1110, NOP=1111), the flag bit indices, and the FSM state encoding.
REQ-018 SHALL be a single module with no sub-modules; the bench SHALL instantiate it with ALU_16B connected on the ALU ports.

Verification
REQ-019 ADD 6,7, RSP_READY=1 -> RSP_VALID rises 2 cycles after acceptance, RSP_DATA=13, Arith flag=1, OP_CNT=1.
REQ-020 SUB 15,4 with RSP_READY=0 for 5 cycles -> RSP_DATA=11 held stable, REQ_READY=0 throughout; second REQ_VALID is ignored until after the handshake.
REQ-021 DIV 14,0 -> with macro: RSP_ERR=1, RSP_DATA=0 one cycle after acceptance, ALU_FUN stays 1111; without macro: RSP_ERR=0, RSP_DATA=0 after 2 cycles.
REQ-022 256 back-to-back CMPG 15,10 -> every RSP_DATA=2; OP_CNT wraps to 0.
REQ-023 RST low during BUSY of MUL 4,3 -> no RSP_VALID, OP_CNT=0, ALU_FUN=1111; next SHL 6 -> RSP_DATA=12.
REQ-024 ALU_LAT=3 build, XOR AAAA,5555 -> RSP_VALID 4 cycles after acceptance, RSP_DATA=FFFF.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : opcodes, flag bit positions and sequencer state encoding       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_XNOR  = 4'b1001;
  localparam logic [3:0] OP_CMPEQ = 4'b1010;
  localparam logic [3:0] OP_CMPG  = 4'b1011;
  localparam logic [3:0] OP_CMPL  = 4'b1100;
  localparam logic [3:0] OP_SHR   = 4'b1101;
  localparam logic [3:0] OP_SHL   = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ARITH = 1;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 3;
  localparam int FLAG_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ALU_16B.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ALU_16B : combinational 16-bit ALU with per-class result flags           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ALU_16B
  import alu_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  ALU_FUN,
  output logic [15:0] ALU_OUT,
  output logic [4:0]  ALU_FLAGS
);

  logic [16:0] ext;
  logic [31:0] prod;

  always_comb begin
    ALU_OUT   = 16'd0;
    ALU_FLAGS = 5'd0;
    ext       = 17'd0;
    prod      = 32'd0;
    case (ALU_FUN)
      OP_ADD: begin
        ext                   = {1'b0, A} + {1'b0, B};
        ALU_OUT               = ext[15:0];
        ALU_FLAGS[FLAG_CARRY] = ext[16];
        ALU_FLAGS[FLAG_ARITH] = 1'b1;
      end
      OP_SUB: begin
        // Carry doubles as borrow-out for subtraction.
        ext                   = {1'b0, A} - {1'b0, B};
        ALU_OUT               = ext[15:0];
        ALU_FLAGS[FLAG_CARRY] = ext[16];
        ALU_FLAGS[FLAG_ARITH] = 1'b1;
      end
      OP_MUL: begin
        prod                  = {16'd0, A} * {16'd0, B};
        ALU_OUT               = prod[15:0];
        ALU_FLAGS[FLAG_CARRY] = |prod[31:16];
        ALU_FLAGS[FLAG_ARITH] = 1'b1;
      end
      OP_DIV: begin
        ALU_OUT               = (B == 16'd0) ? 16'd0 : A / B;
        ALU_FLAGS[FLAG_ARITH] = 1'b1;
      end
      OP_AND:  begin ALU_OUT = A & B;    ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_OR:   begin ALU_OUT = A | B;    ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_NAND: begin ALU_OUT = ~(A & B); ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_NOR:  begin ALU_OUT = ~(A | B); ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_XOR:  begin ALU_OUT = A ^ B;    ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_XNOR: begin ALU_OUT = ~(A ^ B); ALU_FLAGS[FLAG_LOGIC] = 1'b1; end
      OP_CMPEQ: begin
        ALU_OUT             = (A == B) ? 16'd1 : 16'd0;
        ALU_FLAGS[FLAG_CMP] = 1'b1;
      end
      OP_CMPG: begin
        ALU_OUT             = (A > B) ? 16'd2 : 16'd0;
        ALU_FLAGS[FLAG_CMP] = 1'b1;
      end
      OP_CMPL: begin
        ALU_OUT             = (A < B) ? 16'd3 : 16'd0;
        ALU_FLAGS[FLAG_CMP] = 1'b1;
      end
      OP_SHR: begin ALU_OUT = A >> 1; ALU_FLAGS[FLAG_SHIFT] = 1'b1; end
      OP_SHL: begin ALU_OUT = A << 1; ALU_FLAGS[FLAG_SHIFT] = 1'b1; end
      default: begin
        ALU_OUT   = 16'd0;
        ALU_FLAGS = 5'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_cmd_seq : one-at-a-time command sequencer in front of a fixed-latency|
// | ALU. Optional macro ALU_CMD_SEQ_DIV0_CHK_EN rejects divide-by-zero.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  input  logic [3:0]  REQ_FUN,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] ALU_OUT,
  input  logic [4:0]  ALU_FLAGS,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic [4:0]  RSP_FLAGS,
  output logic        RSP_ERR,
  output logic [7:0]  OP_CNT
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  fun_q, fun_d;
  logic [15:0] data_q, data_d;
  logic [4:0]  flags_q, flags_d;
  logic [7:0]  cnt_q, cnt_d;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
  logic        err_q, err_d;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      lat_q   <= 3'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      fun_q   <= OP_NOP;
      data_q  <= 16'd0;
      flags_q <= 5'd0;
      cnt_q   <= 8'd0;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    data_d  = data_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
          // Rejected divides skip the ALU entirely; its ports keep their values.
          if (REQ_FUN == OP_DIV && REQ_B == 16'd0) begin
            data_d  = 16'd0;
            flags_d = 5'd0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else
`endif
          begin
            a_d     = REQ_A;
            b_d     = REQ_B;
            fun_d   = REQ_FUN;
            lat_d   = LAT_INIT;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Counter starts at ALU_LAT, so capture happens ALU_LAT+1 edges later.
        if (lat_q == 3'd0) begin
          data_d  = ALU_OUT;
          flags_d = ALU_FLAGS;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign RSP_VALID = (state_q == ST_RESP);
  assign A         = a_q;
  assign B         = b_q;
  assign ALU_FUN   = (state_q == ST_BUSY) ? fun_q : OP_NOP;
  assign RSP_DATA  = data_q;
  assign RSP_FLAGS = flags_q;
  assign OP_CNT    = cnt_q;
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
  assign RSP_ERR   = err_q;
`else
  assign RSP_ERR   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_cmd_seq : directed bench for alu_cmd_seq with ALU_16B attached    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_cmd_seq;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, RSP_VALID, RSP_READY, RSP_ERR;
  logic [15:0] REQ_A, REQ_B, A, B, ALU_OUT, RSP_DATA;
  logic [3:0]  REQ_FUN, ALU_FUN;
  logic [4:0]  ALU_FLAGS, RSP_FLAGS;
  logic [7:0]  OP_CNT;

  logic        l3_req_valid, l3_req_ready, l3_rsp_valid, l3_rsp_ready, l3_rsp_err;
  logic [15:0] l3_req_a, l3_req_b, l3_a, l3_b, l3_alu_out, l3_rsp_data;
  logic [3:0]  l3_req_fun, l3_alu_fun;
  logic [4:0]  l3_alu_flags, l3_rsp_flags;
  logic [7:0]  l3_op_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_cnt;

  alu_cmd_seq dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUN(REQ_FUN), .A(A), .B(B),
    .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR), .OP_CNT(OP_CNT)
  );

  ALU_16B alu (
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS)
  );

  alu_cmd_seq #(.ALU_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ_VALID(l3_req_valid), .REQ_READY(l3_req_ready),
    .REQ_A(l3_req_a), .REQ_B(l3_req_b), .REQ_FUN(l3_req_fun), .A(l3_a), .B(l3_b),
    .ALU_FUN(l3_alu_fun), .ALU_OUT(l3_alu_out), .ALU_FLAGS(l3_alu_flags),
    .RSP_VALID(l3_rsp_valid), .RSP_READY(l3_rsp_ready), .RSP_DATA(l3_rsp_data),
    .RSP_FLAGS(l3_rsp_flags), .RSP_ERR(l3_rsp_err), .OP_CNT(l3_op_cnt)
  );

  ALU_16B alu3 (
    .A(l3_a), .B(l3_b), .ALU_FUN(l3_alu_fun), .ALU_OUT(l3_alu_out),
    .ALU_FLAGS(l3_alu_flags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one command and returns 1ns after its acceptance edge.
  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    check("req_ready_before_issue", 32'(REQ_READY), 32'd1);
    REQ_FUN   = f;
    REQ_A     = a;
    REQ_B     = b;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (RSP_VALID !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input logic [4:0] exp_flags, input int exp_lat);
    int lat;
    issue(f, a, b);
    wait_rsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(RSP_DATA), 32'(exp_data));
    check({tag, "_flags"}, 32'(RSP_FLAGS), 32'(exp_flags));
    check({tag, "_err"}, 32'(RSP_ERR), 32'd0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    check({tag, "_valid_drop"}, 32'(RSP_VALID), 32'd0);
    check({tag, "_op_cnt"}, 32'(OP_CNT), 32'(exp_cnt));
  endtask

  initial begin
    int lat;
    RST = 1'b0;
    REQ_VALID = 1'b0; REQ_A = 16'd0; REQ_B = 16'd0; REQ_FUN = 4'd0; RSP_READY = 1'b0;
    l3_req_valid = 1'b0; l3_req_a = 16'd0; l3_req_b = 16'd0; l3_req_fun = 4'd0;
    l3_rsp_ready = 1'b1;
    exp_cnt = 8'd0;

    #12;
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    check("rst_rsp_flags", 32'(RSP_FLAGS), 32'd0);
    check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_b", 32'(B), 32'd0);
    check("rst_alu_fun", 32'(ALU_FUN), 32'hF);
    check("rst_op_cnt", 32'(OP_CNT), 32'd0);
    step();
    RST = 1'b1;
    step();
    check("rst_req_ready", 32'(REQ_READY), 32'd1);

    // ADD 6,7 with the consumer always ready.
    RSP_READY = 1'b1;
    issue(OP_ADD, 16'd6, 16'd7);
    check("add_busy_req_ready", 32'(REQ_READY), 32'd0);
    check("add_busy_a", 32'(A), 32'd6);
    check("add_busy_b", 32'(B), 32'd7);
    check("add_busy_fun", 32'(ALU_FUN), 32'(OP_ADD));
    check("add_busy_valid0", 32'(RSP_VALID), 32'd0);
    step();
    check("add_busy_fun2", 32'(ALU_FUN), 32'(OP_ADD));
    check("add_busy_valid1", 32'(RSP_VALID), 32'd0);
    step();
    check("add_rsp_valid", 32'(RSP_VALID), 32'd1);
    check("add_rsp_data", 32'(RSP_DATA), 32'd13);
    check("add_rsp_flags", 32'(RSP_FLAGS), 32'b00010);
    check("add_rsp_fun_nop", 32'(ALU_FUN), 32'hF);
    step();
    exp_cnt = 8'd1;
    check("add_op_cnt", 32'(OP_CNT), 32'd1);
    check("add_idle_ready", 32'(REQ_READY), 32'd1);

    // SUB 15,4 under backpressure while a second command waits.
    RSP_READY = 1'b0;
    issue(OP_SUB, 16'd15, 16'd4);
    REQ_FUN = OP_ADD; REQ_A = 16'd1; REQ_B = 16'd1; REQ_VALID = 1'b1;
    wait_rsp(lat);
    check("sub_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("sub_hold_valid", 32'(RSP_VALID), 32'd1);
      check("sub_hold_data", 32'(RSP_DATA), 32'd11);
      check("sub_hold_flags", 32'(RSP_FLAGS), 32'b00010);
      check("sub_hold_req_ready", 32'(REQ_READY), 32'd0);
      check("sub_hold_a", 32'(A), 32'd15);
      step();
    end
    RSP_READY = 1'b1;
    step();
    exp_cnt = 8'd2;
    check("sub_op_cnt", 32'(OP_CNT), 32'd2);
    check("sub_post_hs_ready", 32'(REQ_READY), 32'd1);
    check("sub_second_not_taken", 32'(A), 32'd15);
    step();
    REQ_VALID = 1'b0;
    check("second_taken_a", 32'(A), 32'd1);
    check("second_busy", 32'(REQ_READY), 32'd0);
    wait_rsp(lat);
    check("second_latency", 32'(lat), 32'd2);
    check("second_data", 32'(RSP_DATA), 32'd2);
    step();
    exp_cnt = 8'd3;
    check("second_op_cnt", 32'(OP_CNT), 32'd3);

    // DIV 14,0
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
    issue(OP_DIV, 16'd14, 16'd0);
    check("div0_valid", 32'(RSP_VALID), 32'd1);
    check("div0_err", 32'(RSP_ERR), 32'd1);
    check("div0_data", 32'(RSP_DATA), 32'd0);
    check("div0_flags", 32'(RSP_FLAGS), 32'd0);
    check("div0_fun", 32'(ALU_FUN), 32'hF);
    check("div0_a_kept", 32'(A), 32'd1);
    check("div0_b_kept", 32'(B), 32'd1);
    step();
    exp_cnt = 8'd4;
    check("div0_op_cnt", 32'(OP_CNT), 32'd4);
`else
    run_cmd("div0", OP_DIV, 16'd14, 16'd0, 16'd0, 5'b00010, 2);
`endif

    // Reset in the middle of MUL 4,3 abandons it.
    issue(OP_MUL, 16'd4, 16'd3);
    check("mul_busy_fun", 32'(ALU_FUN), 32'(OP_MUL));
    #2;
    RST = 1'b0;
    #1;
    check("mulrst_valid", 32'(RSP_VALID), 32'd0);
    check("mulrst_op_cnt", 32'(OP_CNT), 32'd0);
    check("mulrst_fun", 32'(ALU_FUN), 32'hF);
    check("mulrst_a", 32'(A), 32'd0);
    check("mulrst_ready", 32'(REQ_READY), 32'd1);
    exp_cnt = 8'd0;
    step();
    step();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mulrst_no_rsp", 32'(RSP_VALID), 32'd0);
    end
    run_cmd("shl", OP_SHL, 16'd6, 16'd0, 16'd12, 5'b10000, 2);

    // 256 back-to-back CMPG 15,10; OP_CNT passes through 255 -> 0.
    for (int i = 0; i < 256; i++) begin
      run_cmd("cmpg", OP_CMPG, 16'd15, 16'd10, 16'd2, 5'b01000, 2);
    end
    check("cmpg_final_cnt", 32'(OP_CNT), 32'd1);

    // ALU_LAT=3 instance: XOR AAAA,5555.
    check("lat3_ready", 32'(l3_req_ready), 32'd1);
    l3_req_fun = OP_XOR; l3_req_a = 16'hAAAA; l3_req_b = 16'h5555; l3_req_valid = 1'b1;
    step();
    l3_req_valid = 1'b0;
    check("lat3_busy_fun", 32'(l3_alu_fun), 32'(OP_XOR));
    lat = 0;
    while (l3_rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("lat3_latency", 32'(lat), 32'd4);
    check("lat3_data", 32'(l3_rsp_data), 32'hFFFF);
    check("lat3_flags", 32'(l3_rsp_flags), 32'b00100);
    step();
    check("lat3_op_cnt", 32'(l3_op_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
